// File: rtl/btb_pkg.sv
// Shared types and constants for the branch target buffer controller.
// Entry layout, update record and controller state encoding.
package btb_pkg;

    localparam int BTB_ENTRIES = 512;
    localparam int BTB_IDX_W   = $clog2(BTB_ENTRIES);
    localparam int TAG_W       = 5;
    localparam int PC_W        = 14;

    // tag[20:16] | V[15] | S[14] | target[13:0]
    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic             v;
        logic             s;
        logic [PC_W-1:0]  target;
    } btb_entry_t;

    localparam int ENTRY_W = $bits(btb_entry_t);

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic [PC_W-1:0] target;
        logic            taken;
    } btb_upd_t;

    typedef enum logic [1:0] {
        ST_INIT   = 2'd0,
        ST_IDLE   = 2'd1,
        ST_UPD_RD = 2'd2,
        ST_UPD_WR = 2'd3
    } btb_ctrl_state_e;

    function automatic logic [TAG_W-1:0] pc_tag(
        input logic [PC_W-1:0] pc
    );
        return pc[PC_W-1 -: TAG_W];
    endfunction

endpackage

// File: rtl/btb_ctrl_if.sv
// Lookup, update and memory-port signals of the BTB controller.
// master = controller side, slave = fetch/execute/memory side.
interface btb_ctrl_if;
    import btb_pkg::*;

    logic                 lkup_vld;
    logic [PC_W-1:0]      lkup_pc;
    logic                 lkup_rdy;

    logic                 pred_vld;
    logic                 pred_hit;
    logic [PC_W-1:0]      pred_target;

    logic                 upd_vld;
    logic [PC_W-1:0]      upd_pc;
    logic [PC_W-1:0]      upd_target;
    logic                 upd_taken;
    logic                 upd_rdy;

    logic                 mem_en;
    logic                 mem_we;
    logic [BTB_IDX_W-1:0] mem_addr;
    logic [ENTRY_W-1:0]   mem_wdata;
    logic [ENTRY_W-1:0]   mem_rdata;

    modport master (
        input  lkup_vld, lkup_pc,
        input  upd_vld, upd_pc, upd_target, upd_taken,
        input  mem_rdata,
        output lkup_rdy,
        output pred_vld, pred_hit, pred_target,
        output upd_rdy,
        output mem_en, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        output lkup_vld, lkup_pc,
        output upd_vld, upd_pc, upd_target, upd_taken,
        output mem_rdata,
        input  lkup_rdy,
        input  pred_vld, pred_hit, pred_target,
        input  upd_rdy,
        input  mem_en, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/btb_upd_fifo.sv
// Small synchronous FIFO holding resolved branch updates.
// Extra pointer bit distinguishes full from empty.
module btb_upd_fifo
    import btb_pkg::*;
#(
    parameter int UPD_DEPTH = 4
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     clr_i,
    input  logic     push_i,
    input  btb_upd_t push_data_i,
    input  logic     pop_i,
    output btb_upd_t head_o,
    output logic     full_o,
    output logic     empty_o
);

    localparam int PW = $clog2(UPD_DEPTH);

    btb_upd_t        mem_q [UPD_DEPTH];
    logic [PW:0]     wr_q, wr_d;
    logic [PW:0]     rd_q, rd_d;
    logic            do_push;
    logic            do_pop;

    assign empty_o = (wr_q == rd_q);
    assign full_o  = (wr_q[PW] != rd_q[PW]) &&
                     (wr_q[PW-1:0] == rd_q[PW-1:0]);
    assign head_o  = mem_q[rd_q[PW-1:0]];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // Pointer advance; clear wins over push/pop.
    always_comb begin
        wr_d = wr_q;
        rd_d = rd_q;
        if (clr_i) begin
            wr_d = '0;
            rd_d = '0;
        end else begin
            if (do_push) wr_d = wr_q + (PW+1)'(1);
            if (do_pop)  rd_d = rd_q + (PW+1)'(1);
        end
    end

    // Pointer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    // Entry storage, written at the tail on push.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < UPD_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (do_push && !clr_i) begin
            mem_q[wr_q[PW-1:0]] <= push_data_i;
        end
    end

endmodule

// File: rtl/btb_ctrl.sv
// BTB memory-port owner: clear sweep, lookup/update arbitration,
// and read-modify-write of valid/hysteresis bits per entry.
module btb_ctrl
    import btb_pkg::*;
#(
    parameter int UPD_DEPTH  = 4,
    parameter int STARVE_MAX = 8,
    parameter int IDX_W      = BTB_IDX_W
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       flush,
    btb_ctrl_if.master bus,
    output logic       init_done
);

    localparam int SC_W = $clog2(STARVE_MAX + 1);
    localparam logic [SC_W-1:0] SC_MAX = SC_W'(STARVE_MAX);

    btb_ctrl_state_e  state_q, state_d;
    btb_ctrl_state_e  st;
    logic [IDX_W-1:0] sweep_q, sweep_d;
    logic [SC_W-1:0]  starve_q, starve_d;
    logic             init_done_q, init_done_d;
    logic             pend_q;
    logic [TAG_W-1:0] ltag_q;

    btb_upd_t         head;
    btb_upd_t         push_data;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;

    logic             start_upd;
    logic             grant;
    btb_entry_t       rd_e;
    btb_entry_t       wr_e;
    logic             upd_hit;
    logic             wr_en;
    logic [TAG_W-1:0] upd_tag;

    assign push_data = '{
        pc:     bus.upd_pc,
        target: bus.upd_target,
        taken:  bus.upd_taken
    };

    assign push = bus.upd_vld && bus.upd_rdy;
    assign pop  = (st == ST_UPD_WR) && !flush;

    btb_upd_fifo #(
        .UPD_DEPTH (UPD_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .clr_i       (flush),
        .push_i      (push),
        .push_data_i (push_data),
        .pop_i       (pop),
        .head_o      (head),
        .full_o      (full),
        .empty_o     (empty)
    );

    // The IDLE cycle that starts an update is itself the read cycle,
    // so an update costs exactly two port cycles.
    assign start_upd = (state_q == ST_IDLE) && !empty &&
                       (full || (starve_q == SC_MAX) ||
                        !bus.lkup_vld);
    assign st        = start_upd ? ST_UPD_RD : state_q;

    assign grant         = (st == ST_IDLE) && bus.lkup_vld && !flush;
    assign bus.lkup_rdy  = (st == ST_IDLE) && !flush;
    assign bus.upd_rdy   = init_done_q && !full && !flush;
    assign init_done     = init_done_q;

    assign rd_e    = btb_entry_t'(bus.mem_rdata);
    assign upd_tag = pc_tag(head.pc);
    assign upd_hit = rd_e.v && (rd_e.tag == upd_tag);

    // Prediction from the entry read in the previous (granted) cycle.
    assign bus.pred_vld    = pend_q && !flush;
    assign bus.pred_hit    = bus.pred_vld && rd_e.v &&
                             (rd_e.tag == ltag_q);
    assign bus.pred_target = bus.pred_hit ? rd_e.target : '0;

    // New entry contents for the write half of an update.
    always_comb begin
        wr_e  = rd_e;
        wr_en = 1'b1;
        if (head.taken) begin
            wr_e.tag    = upd_tag;
            wr_e.v      = 1'b1;
            wr_e.s      = upd_hit;
            wr_e.target = head.target;
        end else if (upd_hit && rd_e.s) begin
            wr_e.s = 1'b0;
        end else if (upd_hit) begin
            wr_e.v = 1'b0;
        end else begin
            wr_en = 1'b0;
        end
    end

    // Memory port drive; flush blocks all access that cycle.
    always_comb begin
        bus.mem_en    = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        if (!flush) begin
            unique case (st)
                ST_INIT: begin
                    bus.mem_en   = rst_n;
                    bus.mem_we   = rst_n;
                    bus.mem_addr = sweep_q;
                end
                ST_IDLE: begin
                    if (bus.lkup_vld) begin
                        bus.mem_en   = 1'b1;
                        bus.mem_addr = bus.lkup_pc[IDX_W-1:0];
                    end
                end
                ST_UPD_RD: begin
                    bus.mem_en   = 1'b1;
                    bus.mem_addr = head.pc[IDX_W-1:0];
                end
                ST_UPD_WR: begin
                    bus.mem_en    = wr_en;
                    bus.mem_we    = wr_en;
                    bus.mem_addr  = head.pc[IDX_W-1:0];
                    bus.mem_wdata = wr_e;
                end
                default: ;
            endcase
        end
    end

    // Next state, sweep address, starvation counter.
    always_comb begin
        state_d     = state_q;
        sweep_d     = sweep_q;
        starve_d    = starve_q;
        init_done_d = init_done_q;
        if (flush) begin
            state_d     = ST_INIT;
            sweep_d     = '0;
            starve_d    = '0;
            init_done_d = 1'b0;
        end else begin
            unique case (st)
                ST_INIT: begin
                    sweep_d = sweep_q + IDX_W'(1);
                    if (sweep_q == '1) begin
                        state_d     = ST_IDLE;
                        init_done_d = 1'b1;
                    end
                end
                ST_IDLE: begin
                    if (empty) begin
                        starve_d = '0;
                    end else if (bus.lkup_vld &&
                                 starve_q != SC_MAX) begin
                        starve_d = starve_q + SC_W'(1);
                    end
                end
                ST_UPD_RD: begin
                    starve_d = '0;
                    state_d  = ST_UPD_WR;
                end
                ST_UPD_WR: begin
                    state_d = ST_IDLE;
                end
                default: ;
            endcase
        end
    end

    // Control registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_INIT;
            sweep_q     <= '0;
            starve_q    <= '0;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sweep_q     <= sweep_d;
            starve_q    <= starve_d;
            init_done_q <= init_done_d;
        end
    end

    // Pending-prediction flag and tag of the granted lookup.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q <= 1'b0;
            ltag_q <= '0;
        end else begin
            pend_q <= grant;
            if (grant) begin
                ltag_q <= pc_tag(bus.lkup_pc);
            end
        end
    end

endmodule

// File: tb/tb_btb_ctrl.sv
// Scenario bench for btb_ctrl with a behavioural 512x21 memory
// and a reference model feeding prediction/write scoreboards.
module tb_btb_ctrl;
    import btb_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    logic flush;
    logic init_done;

    btb_ctrl_if bus ();

    btb_ctrl #(
        .UPD_DEPTH  (4),
        .STARVE_MAX (8),
        .IDX_W      (9)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .bus       (bus),
        .init_done (init_done)
    );

    always #5 clk = ~clk;

    logic [20:0] bmem [512];

    always @(posedge clk) begin
        if (bus.mem_en) begin
            if (bus.mem_we) bmem[bus.mem_addr] <= bus.mem_wdata;
            else            bus.mem_rdata <= bmem[bus.mem_addr];
        end
    end

    int checks = 0;
    int failures = 0;

    logic [20:0] ref_mem [512];
    logic [14:0] exp_pred [$];
    logic [29:0] exp_wr [$];
    int          sweep_exp;

    logic        s_lkup_rdy, s_upd_rdy, s_init_done;
    logic        s_en, s_we, s_grant, s_push;
    logic [8:0]  s_addr;
    logic [20:0] s_wdata;
    logic        s_pred_vld, s_pred_hit;
    logic [13:0] s_pred_target;

    function automatic logic [14:0] model_lookup(input logic [13:0] pc);
        logic [20:0] e;
        logic        h;
        e = ref_mem[pc[8:0]];
        h = e[15] && (e[20:16] == pc[13:9]);
        return {h, h ? e[13:0] : 14'h0};
    endfunction

    task automatic model_update(input logic [13:0] pc,
                                input logic [13:0] tgt,
                                input logic tk);
        logic [20:0] e, n;
        logic        h;
        logic [8:0]  ix;
        logic [4:0]  tg;
        ix = pc[8:0];
        tg = pc[13:9];
        e  = ref_mem[ix];
        h  = e[15] && (e[20:16] == tg);
        if (tk && h)        n = {tg, 2'b11, tgt};
        else if (tk)        n = {tg, 2'b10, tgt};
        else if (h && e[14]) n = {e[20:15], 1'b0, e[13:0]};
        else if (h)         n = {e[20:16], 2'b00, e[13:0]};
        else                return;
        ref_mem[ix] = n;
        exp_wr.push_back({ix, n});
    endtask

    // One clock: sample mid-cycle, run scoreboards, advance.
    task automatic step();
        logic [14:0] ep;
        logic [29:0] ew;
        #4;
        s_lkup_rdy    = bus.lkup_rdy;
        s_upd_rdy     = bus.upd_rdy;
        s_init_done   = init_done;
        s_en          = bus.mem_en;
        s_we          = bus.mem_we;
        s_addr        = bus.mem_addr;
        s_wdata       = bus.mem_wdata;
        s_pred_vld    = bus.pred_vld;
        s_pred_hit    = bus.pred_hit;
        s_pred_target = bus.pred_target;
        s_grant       = bus.lkup_vld && bus.lkup_rdy;
        s_push        = bus.upd_vld && bus.upd_rdy;
        if (s_pred_vld) begin
            checks++;
            if (exp_pred.size() == 0) begin
                failures++;
                $display("FAIL pred_unexpected got hit=%0b tgt=%h want none",
                         s_pred_hit, s_pred_target);
            end else begin
                ep = exp_pred.pop_front();
                if ({s_pred_hit, s_pred_target} !== ep) begin
                    failures++;
                    $display("FAIL pred got hit=%0b tgt=%h want hit=%0b tgt=%h",
                             s_pred_hit, s_pred_target, ep[14], ep[13:0]);
                end
            end
        end
        if (s_en && s_we) begin
            checks++;
            if (!s_init_done) begin
                if (s_addr !== sweep_exp[8:0] || s_wdata !== 21'h0 ||
                    sweep_exp > 511) begin
                    failures++;
                    $display("FAIL sweep got addr=%0d data=%h want addr=%0d data=0",
                             s_addr, s_wdata, sweep_exp);
                end
                sweep_exp++;
            end else if (exp_wr.size() == 0) begin
                failures++;
                $display("FAIL wr_unexpected got addr=%h data=%h want none",
                         s_addr, s_wdata);
            end else begin
                ew = exp_wr.pop_front();
                if ({s_addr, s_wdata} !== ew) begin
                    failures++;
                    $display("FAIL wr got addr=%h data=%h want addr=%h data=%h",
                             s_addr, s_wdata, ew[29:21], ew[20:0]);
                end
            end
        end
        if (s_grant) exp_pred.push_back(model_lookup(bus.lkup_pc));
        if (s_push) model_update(bus.upd_pc, bus.upd_target, bus.upd_taken);
        if (flush) begin
            exp_pred.delete();
            exp_wr.delete();
            for (int i = 0; i < 512; i++) ref_mem[i] = '0;
            sweep_exp = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_init();
        int n = 0;
        int bad = 0;
        do begin
            step();
            n++;
            if (!s_init_done && (s_lkup_rdy || s_upd_rdy)) bad++;
        end while (!s_init_done && n < 700);
        checks++;
        if (!s_init_done) begin
            failures++;
            $display("FAIL init_timeout got init_done=0 after %0d want 1", n);
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL rdy_during_init got %0d cycles want 0", bad);
        end
        checks++;
        if (sweep_exp != 512 || n != 513) begin
            failures++;
            $display("FAIL sweep_len got writes=%0d cycles=%0d want 512/513",
                     sweep_exp, n);
        end
    endtask

    task automatic do_update(input logic [13:0] pc,
                             input logic [13:0] tgt,
                             input logic tk);
        bus.upd_vld    = 1'b1;
        bus.upd_pc     = pc;
        bus.upd_target = tgt;
        bus.upd_taken  = tk;
        step();
        bus.upd_vld = 1'b0;
        checks++;
        if (!s_push) begin
            failures++;
            $display("FAIL upd_push got rdy=%0b want 1", s_upd_rdy);
        end
    endtask

    task automatic do_lookup(input logic [13:0] pc,
                             input logic want_hit,
                             input logic [13:0] want_tgt);
        bus.lkup_vld = 1'b1;
        bus.lkup_pc  = pc;
        step();
        bus.lkup_vld = 1'b0;
        checks++;
        if (!s_grant) begin
            failures++;
            $display("FAIL lkup_grant pc=%h got 0 want 1", pc);
        end
        step();
        checks++;
        if ({s_pred_vld, s_pred_hit, s_pred_target} !==
            {1'b1, want_hit, want_tgt}) begin
            failures++;
            $display("FAIL lkup pc=%h got v=%0b hit=%0b tgt=%h want 1/%0b/%h",
                     pc, s_pred_vld, s_pred_hit, s_pred_target,
                     want_hit, want_tgt);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        flush = 1'b0;
        bus.lkup_vld = 1'b0;
        bus.lkup_pc = '0;
        bus.upd_vld = 1'b0;
        bus.upd_pc = '0;
        bus.upd_target = '0;
        bus.upd_taken = 1'b0;
        for (int i = 0; i < 512; i++) ref_mem[i] = '0;
        sweep_exp = 0;
        repeat (2) @(posedge clk);
        #3;
        checks++;
        if ({bus.lkup_rdy, bus.upd_rdy, bus.pred_vld, bus.mem_en,
             bus.mem_we, init_done} !== 6'b0) begin
            failures++;
            $display("FAIL reset_ctl got %b want 000000",
                     {bus.lkup_rdy, bus.upd_rdy, bus.pred_vld,
                      bus.mem_en, bus.mem_we, init_done});
        end
        checks++;
        if (bus.mem_addr !== 9'h0 || bus.mem_wdata !== 21'h0) begin
            failures++;
            $display("FAIL reset_bus got addr=%h data=%h want 0/0",
                     bus.mem_addr, bus.mem_wdata);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        wait_init();
    endtask

    task automatic test_alloc();
        do_update(14'h0A05, 14'h1234, 1'b1);
        step();
        checks++;
        if (!(s_en && !s_we && s_addr == 9'h005) || s_lkup_rdy) begin
            failures++;
            $display("FAIL upd_rd got en=%0b we=%0b addr=%h rdy=%0b want 1/0/005/0",
                     s_en, s_we, s_addr, s_lkup_rdy);
        end
        step();
        checks++;
        if (!(s_en && s_we) || s_addr !== 9'h005 ||
            s_wdata !== 21'h059234) begin
            failures++;
            $display("FAIL upd_wr got we=%0b addr=%h data=%h want 1/005/059234",
                     s_we, s_addr, s_wdata);
        end
        step();
        do_lookup(14'h0A05, 1'b1, 14'h1234);
    endtask

    task automatic test_hysteresis();
        do_update(14'h0A05, 14'h1234, 1'b1);
        do_update(14'h0A05, 14'h1234, 1'b0);
        do_update(14'h0A05, 14'h1234, 1'b0);
        repeat (8) step();
        checks++;
        if (bmem[5] !== 21'h051234) begin
            failures++;
            $display("FAIL hyst_entry got %h want 051234", bmem[5]);
        end
        do_lookup(14'h0A05, 1'b0, 14'h0);
    endtask

    task automatic test_alias();
        do_update(14'h0A05, 14'h1234, 1'b1);
        repeat (4) step();
        do_lookup(14'h0C05, 1'b0, 14'h0);
        do_lookup(14'h0A05, 1'b1, 14'h1234);
        do_update(14'h0123, 14'h0777, 1'b0);
        step();
        step();
        checks++;
        if (s_en || s_we) begin
            failures++;
            $display("FAIL miss_nt got en=%0b we=%0b want 0/0", s_en, s_we);
        end
        step();
    endtask

    task automatic test_starve();
        int g = 0;
        int z = 0;
        bus.lkup_vld = 1'b1;
        bus.lkup_pc  = 14'h0100;
        do_update(14'h0010, 14'h0AAA, 1'b1);
        for (int i = 0; i < 40; i++) begin
            bus.lkup_pc = 14'h0101 + 14'(i);
            step();
            if (!s_lkup_rdy) break;
            g++;
        end
        z = 1;
        for (int i = 0; i < 40; i++) begin
            step();
            if (s_lkup_rdy) break;
            z++;
        end
        bus.lkup_vld = 1'b0;
        step();
        checks++;
        if (g != 8) begin
            failures++;
            $display("FAIL starve_grants got %0d want 8", g);
        end
        checks++;
        if (z != 2) begin
            failures++;
            $display("FAIL starve_block got %0d want 2", z);
        end
    endtask

    task automatic test_full();
        int pushes = 0;
        bus.lkup_vld = 1'b1;
        bus.lkup_pc  = 14'h0180;
        bus.upd_vld  = 1'b1;
        bus.upd_taken = 1'b1;
        for (int i = 0; i < 20 && pushes < 4; i++) begin
            bus.upd_pc     = 14'h0640 + 14'(pushes);
            bus.upd_target = 14'h0300 + 14'(pushes);
            step();
            if (s_push) pushes++;
        end
        bus.upd_vld = 1'b0;
        checks++;
        if (pushes != 4) begin
            failures++;
            $display("FAIL full_pushes got %0d want 4", pushes);
        end
        step();
        checks++;
        if (s_upd_rdy || s_lkup_rdy || !s_en || s_we ||
            s_addr !== 9'h040) begin
            failures++;
            $display("FAIL full_force got urdy=%0b lrdy=%0b addr=%h want 0/0/040",
                     s_upd_rdy, s_lkup_rdy, s_addr);
        end
        bus.lkup_vld = 1'b0;
        repeat (10) step();
        checks++;
        if (bmem[9'h043] !== 21'h038303) begin
            failures++;
            $display("FAIL full_last got %h want 038303", bmem[9'h043]);
        end
    endtask

    task automatic test_flush();
        do_update(14'h0077, 14'h0555, 1'b1);
        step();
        flush = 1'b1;
        step();
        checks++;
        if (s_we || s_lkup_rdy || s_upd_rdy) begin
            failures++;
            $display("FAIL flush_wr got we=%0b lrdy=%0b urdy=%0b want 0/0/0",
                     s_we, s_lkup_rdy, s_upd_rdy);
        end
        step();
        step();
        checks++;
        if (s_en || s_init_done) begin
            failures++;
            $display("FAIL flush_hold got en=%0b init=%0b want 0/0",
                     s_en, s_init_done);
        end
        flush = 1'b0;
        wait_init();
        do_lookup(14'h0077, 1'b0, 14'h0);
        do_lookup(14'h0A05, 1'b0, 14'h0);
        bus.lkup_vld = 1'b1;
        bus.lkup_pc  = 14'h0A05;
        step();
        bus.lkup_vld = 1'b0;
        flush = 1'b1;
        step();
        checks++;
        if (s_pred_vld) begin
            failures++;
            $display("FAIL flush_pred got pred_vld=1 want 0");
        end
        flush = 1'b0;
        wait_init();
    endtask

    initial begin
        test_reset();
        test_alloc();
        test_hysteresis();
        test_alias();
        test_starve();
        test_full();
        test_flush();
        repeat (3) step();
        checks++;
        if (exp_pred.size() != 0 || exp_wr.size() != 0) begin
            failures++;
            $display("FAIL leftover got pred=%0d wr=%0d want 0/0",
                     exp_pred.size(), exp_wr.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
